// File: rtl/regfile8x16.sv
// regfile8x16: 8x16 register bank fed by a 1:8 write demux.
// Two registered read ports with write-through bypass and a busy scoreboard.
module regfile8x16 #(
    parameter int DW   = 16,
    parameter int NREG = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    input  logic [DW-1:0]   c,
    input  logic [DW-1:0]   d,
    input  logic [DW-1:0]   e,
    input  logic [DW-1:0]   f,
    input  logic [DW-1:0]   g,
    input  logic [DW-1:0]   h,
    input  logic [2:0]      wr_sel,
    input  logic            wr_en,
    input  logic            clr,
    input  logic            rsv_en,
    input  logic [2:0]      rsv_addr,
    input  logic [2:0]      ra_addr,
    input  logic [2:0]      rb_addr,
    output logic [DW-1:0]   ra_data,
    output logic [DW-1:0]   rb_data,
    output logic            ra_busy,
    output logic            rb_busy,
    output logic [NREG-1:0] busy_vec
);

    logic [DW-1:0]   r_reg [NREG];
    logic [NREG-1:0] r_busy;

    logic [DW-1:0]   w_lanes [NREG];
    logic [DW-1:0]   w_lane;
    logic [NREG-1:0] w_busy_nxt;
    logic [DW-1:0]   w_ra_nxt;
    logic [DW-1:0]   w_rb_nxt;
    logic            w_ra_hit;
    logic            w_rb_hit;

    assign w_lanes[0] = a;
    assign w_lanes[1] = b;
    assign w_lanes[2] = c;
    assign w_lanes[3] = d;
    assign w_lanes[4] = e;
    assign w_lanes[5] = f;
    assign w_lanes[6] = g;
    assign w_lanes[7] = h;

    assign w_lane   = w_lanes[wr_sel];
    assign w_ra_hit = wr_en && (wr_sel == ra_addr);
    assign w_rb_hit = wr_en && (wr_sel == rb_addr);

    // Reserve beats write: the new producer owns the register.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int i = 0; i < NREG; i++) begin
            if (clr)
                w_busy_nxt[i] = 1'b0;
            else if (rsv_en && rsv_addr == 3'(i))
                w_busy_nxt[i] = 1'b1;
            else if (wr_en && wr_sel == 3'(i))
                w_busy_nxt[i] = 1'b0;
        end
    end

    always_comb begin
        w_ra_nxt = r_reg[ra_addr];
        w_rb_nxt = r_reg[rb_addr];
        if (clr) begin
            w_ra_nxt = '0;
            w_rb_nxt = '0;
        end else begin
            if (w_ra_hit)
                w_ra_nxt = w_lane;
            if (w_rb_hit)
                w_rb_nxt = w_lane;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++)
                r_reg[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < NREG; i++)
                r_reg[i] <= '0;
        end else if (wr_en) begin
            r_reg[wr_sel] <= w_lane;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy  <= '0;
            ra_data <= '0;
            rb_data <= '0;
            ra_busy <= 1'b0;
            rb_busy <= 1'b0;
        end else begin
            r_busy  <= w_busy_nxt;
            ra_data <= w_ra_nxt;
            rb_data <= w_rb_nxt;
            ra_busy <= w_busy_nxt[ra_addr];
            rb_busy <= w_busy_nxt[rb_addr];
        end
    end

    assign busy_vec = r_busy;

endmodule

// File: tb/tb_regfile8x16.sv
// tb_regfile8x16: directed and random checks of regfile8x16
// against an array-based model of the register bank and scoreboard.
module tb_regfile8x16;

    logic        clk;
    logic        rst_n;
    logic [15:0] lane [8];
    logic [2:0]  wr_sel;
    logic        wr_en;
    logic        clr;
    logic        rsv_en;
    logic [2:0]  rsv_addr;
    logic [2:0]  ra_addr;
    logic [2:0]  rb_addr;
    logic [15:0] ra_data;
    logic [15:0] rb_data;
    logic        ra_busy;
    logic        rb_busy;
    logic [7:0]  busy_vec;

    int total = 0;
    int bad   = 0;

    logic [15:0] m_reg [8];
    logic [7:0]  m_busy;
    logic [15:0] m_ra;
    logic [15:0] m_rb;
    logic        m_rab;
    logic        m_rbb;

    regfile8x16 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a        (lane[0]),
        .b        (lane[1]),
        .c        (lane[2]),
        .d        (lane[3]),
        .e        (lane[4]),
        .f        (lane[5]),
        .g        (lane[6]),
        .h        (lane[7]),
        .wr_sel   (wr_sel),
        .wr_en    (wr_en),
        .clr      (clr),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .ra_addr  (ra_addr),
        .rb_addr  (rb_addr),
        .ra_data  (ra_data),
        .rb_data  (rb_data),
        .ra_busy  (ra_busy),
        .rb_busy  (rb_busy),
        .busy_vec (busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_reg[i] = '0;
        m_busy = '0;
        m_ra = '0;
        m_rb = '0;
        m_rab = 1'b0;
        m_rbb = 1'b0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".ra_data"}, ra_data, m_ra);
        chk({tag, ".rb_data"}, rb_data, m_rb);
        chk({tag, ".ra_busy"}, 16'(ra_busy), 16'(m_rab));
        chk({tag, ".rb_busy"}, 16'(rb_busy), 16'(m_rbb));
        chk({tag, ".busy_vec"}, 16'(busy_vec), 16'(m_busy));
    endtask

    // One clock: drive, update model from the rules, check after the edge.
    task automatic step(input string tag, input logic we,
                        input logic [2:0] ws, input logic [15:0] val,
                        input logic [15:0] other, input logic cl,
                        input logic rv, input logic [2:0] radr,
                        input logic [2:0] ra, input logic [2:0] rb);
        logic [7:0] nb;
        for (int i = 0; i < 8; i++) lane[i] = other;
        lane[ws] = val;
        wr_en = we; wr_sel = ws; clr = cl;
        rsv_en = rv; rsv_addr = radr;
        ra_addr = ra; rb_addr = rb;
        if (cl) begin
            for (int i = 0; i < 8; i++) m_reg[i] = '0;
            m_busy = '0;
            m_ra = '0; m_rb = '0; m_rab = 1'b0; m_rbb = 1'b0;
        end else begin
            m_ra = (we && ws == ra) ? val : m_reg[ra];
            m_rb = (we && ws == rb) ? val : m_reg[rb];
            nb = m_busy;
            if (we) nb[ws] = 1'b0;
            if (rv) nb[radr] = 1'b1;
            m_busy = nb;
            m_rab = nb[ra];
            m_rbb = nb[rb];
            if (we) m_reg[ws] = val;
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle_read(input string tag, input logic [2:0] ra,
                             input logic [2:0] rb);
        step(tag, 1'b0, 3'd0, 16'h0, 16'h0, 1'b0, 1'b0, 3'd0, ra, rb);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) lane[i] = '0;
        wr_en = 0; wr_sel = 0; clr = 0; rsv_en = 0; rsv_addr = 0;
        ra_addr = 0; rb_addr = 0;
        rst_n = 1'b0;
        model_reset();
        #3;
        check_all("por");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // reset: preload 0xFFFF with all reserved, then async reset
        for (int i = 0; i < 8; i++)
            step("pre", 1'b1, 3'(i), 16'hFFFF, 16'h0, 1'b0, 1'b1,
                 3'(i), 3'(i), 3'(7 - i));
        chk("pre.busy_ff", 16'(busy_vec), 16'h00FF);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("rst_async");
        chk("rst.busy0", 16'(busy_vec), 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++)
            idle_read("rst_rd", 3'(i), 3'(7 - i));

        // write all with foreign lanes at 0xDEAD
        for (int i = 0; i < 8; i++)
            step("wr", 1'b1, 3'(i), 16'(16'h1111 * i), 16'hDEAD, 1'b0,
                 1'b0, 3'd0, 3'd0, 3'd0);
        for (int i = 0; i < 8; i++) begin
            idle_read("rd", 3'(i), 3'(7 - i));
            chk("rd.const_a", ra_data, 16'(16'h1111 * i));
            chk("rd.const_b", rb_data, 16'(16'h1111 * (7 - i)));
        end

        // bypass on both ports
        step("byp0", 1'b1, 3'd3, 16'h0001, 16'h0, 1'b0, 1'b0, 3'd0,
             3'd0, 3'd1);
        step("byp", 1'b1, 3'd3, 16'hBEEF, 16'h0, 1'b0, 1'b0, 3'd0,
             3'd3, 3'd3);
        chk("byp.a", ra_data, 16'hBEEF);
        chk("byp.b", rb_data, 16'hBEEF);

        // scoreboard
        step("sb_rsv", 1'b0, 3'd0, 16'h0, 16'h0, 1'b0, 1'b1, 3'd5,
             3'd5, 3'd0);
        chk("sb.rsv", 16'(busy_vec), 16'h0020);
        step("sb_both", 1'b1, 3'd5, 16'h1234, 16'h0, 1'b0, 1'b1, 3'd5,
             3'd0, 3'd5);
        chk("sb.both", 16'(busy_vec), 16'h0020);
        idle_read("sb_rd", 3'd5, 3'd5);
        chk("sb.data", ra_data, 16'h1234);
        step("sb_wr", 1'b1, 3'd5, 16'h4321, 16'h0, 1'b0, 1'b0, 3'd0,
             3'd5, 3'd5);
        chk("sb.wr", 16'(busy_vec), 16'h0000);

        // clear beats write
        step("cl_pre", 1'b1, 3'd2, 16'h00AA, 16'h0, 1'b0, 1'b0, 3'd0,
             3'd2, 3'd2);
        for (int i = 0; i < 8; i++)
            step("cl_rsv", 1'b0, 3'd0, 16'h0, 16'h0, 1'b0, 1'b1,
                 3'(i), 3'd2, 3'd0);
        chk("cl.busyff", 16'(busy_vec), 16'h00FF);
        step("cl", 1'b1, 3'd2, 16'h5555, 16'h0, 1'b1, 1'b0, 3'd0,
             3'd2, 3'd2);
        chk("cl.busy", 16'(busy_vec), 16'h0000);
        chk("cl.ra", ra_data, 16'h0000);
        for (int i = 0; i < 8; i++)
            idle_read("cl_rd", 3'(i), 3'(i));

        // reset held across an edge carrying a write and reserve
        step("mid_pre", 1'b1, 3'd6, 16'h7777, 16'h0, 1'b0, 1'b0, 3'd0,
             3'd6, 3'd6);
        lane[1] = 16'hCAFE; wr_sel = 3'd1; wr_en = 1'b1;
        rsv_en = 1'b1; rsv_addr = 3'd1; ra_addr = 3'd1; rb_addr = 3'd6;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("mid_async");
        @(posedge clk);
        #1;
        check_all("mid_edge");
        wr_en = 1'b0; rsv_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle_read("mid_rd", 3'd1, 3'd6);

        // random traffic, all lanes random so foreign lanes must be ignored
        for (int n = 0; n < 400; n++)
            step("rnd", 1'($urandom), 3'($urandom), 16'($urandom),
                 16'($urandom), ($urandom_range(0, 31) == 0),
                 1'($urandom), 3'($urandom), 3'($urandom), 3'($urandom));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
